// File: rtl/pressure_alarm_pkg.sv
// pressure_alarm_pkg
// Shared types and constants for the pressure alarm controller:
//   - alarmState_e : FSM state enum (NORMAL=0, SUSPECT=1, ALARM=2, RECOVER=3)
//   - CNT_W/CNT_MAX: run/clear counter width and saturation value
//   - DEF_*        : default parameter values of the controller
//   - satInc       : saturating increment for the 4-bit counters
package pressure_alarm_pkg;

  localparam int unsigned CNT_W             = 4;
  localparam int unsigned CNT_MAX           = 15;
  localparam int unsigned PRESSURE_W        = 6;
  localparam int unsigned STATE_W           = 2;
  localparam int unsigned DEF_CONFIRM_COUNT = 4;
  localparam int unsigned DEF_CLEAR_COUNT   = 8;
  localparam int unsigned DEF_EVT_W         = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_NORMAL  = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_ALARM   = 2'd2,
    ST_RECOVER = 2'd3
  } alarmState_e;

  // Increment that holds at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == CNT_W'(CNT_MAX)) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pressure_run_counter.sv
// pressure_run_counter
// Saturating 4-bit consecutive-sample counter.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   inc         : count one more sample this cycle
//   clr         : restart the run at 0 (wins over inc)
//   reached_c   : combinational; this cycle's increment brings the count to THRESHOLD
module pressure_run_counter
  import pressure_alarm_pkg::*;
#(
  parameter int unsigned THRESHOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic reached_c
);

  logic [CNT_W-1:0] count;

  // Run length register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= satInc(count);
    end
  end

  // Lets the owner act on the same edge the threshold is met.
  assign reached_c = inc && (satInc(count) >= CNT_W'(THRESHOLD));

endmodule

// File: rtl/pressure_alarm_controller.sv
// pressure_alarm_controller
// Debounces an upstream pressure abnormality flag into a latched alarm with
// operator acknowledge, episode counting and optional peak tracking.
// Optional feature: define PRESSURE_PEAK_TRACK_EN to track peak pressure;
// otherwise peak_pressure is tied to 0.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   sample_valid        : strobe qualifying pressure_abnormal/pressure_data
//   pressure_abnormal   : abnormality flag from the detector
//   pressure_data       : raw pressure sample
//   alarm_ack           : operator acknowledge level
//   alarm               : latched alarm (registered)
//   buzzer              : alarm and not yet acknowledged (registered)
//   alarm_state         : FSM state encoding (registered)
//   event_count         : saturating count of alarms raised (registered)
//   peak_pressure       : peak sample of the current/last abnormal episode
module pressure_alarm_controller
  import pressure_alarm_pkg::*;
#(
  parameter int unsigned CONFIRM_COUNT = DEF_CONFIRM_COUNT,
  parameter int unsigned CLEAR_COUNT   = DEF_CLEAR_COUNT,
  parameter int unsigned EVT_W         = DEF_EVT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic                  pressure_abnormal,
  input  logic [PRESSURE_W-1:0] pressure_data,
  input  logic                  alarm_ack,
  output logic                  alarm,
  output logic                  buzzer,
  output logic [STATE_W-1:0]    alarm_state,
  output logic [EVT_W-1:0]      event_count,
  output logic [PRESSURE_W-1:0] peak_pressure
);

  alarmState_e      state;
  alarmState_e      stateNext;
  logic             alarmQ;
  logic             alarmNext;
  logic             ackQ;
  logic             ackNext;
  logic             buzzerQ;
  logic             buzzerNext;
  logic [EVT_W-1:0] evtQ;
  logic [EVT_W-1:0] evtNext;

  logic validAbn;
  logic validNorm;
  logic runInc;
  logic runClr;
  logic runHit;
  logic clrInc;
  logic clrClr;
  logic clrHit;

  assign validAbn  = sample_valid && pressure_abnormal;
  assign validNorm = sample_valid && !pressure_abnormal;

  // Abnormal run: only counts while not alarmed; in NORMAL it always sits at 0,
  // so the first abnormal sample yields a run of 1.
  assign runInc = validAbn && ((state == ST_NORMAL) || (state == ST_SUSPECT));
  assign runClr = ((state == ST_SUSPECT) && validNorm) || runHit;

  pressure_run_counter #(
    .THRESHOLD(CONFIRM_COUNT)
  ) uRunCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (runInc),
    .clr      (runClr),
    .reached_c(runHit)
  );

  // Normal run while alarmed; held at 0 outside ALARM so re-entry starts fresh.
  assign clrInc = (state == ST_ALARM) && validNorm;
  assign clrClr = (state != ST_ALARM) || validAbn;

  pressure_run_counter #(
    .THRESHOLD(CLEAR_COUNT)
  ) uClearCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (clrInc),
    .clr      (clrClr),
    .reached_c(clrHit)
  );

  // Next-state and next-output logic.
  always_comb begin
    stateNext = state;
    alarmNext = alarmQ;
    ackNext   = ackQ;
    evtNext   = evtQ;

    unique case (state)
      ST_NORMAL, ST_SUSPECT: begin
        if (runHit) begin
          stateNext = ST_ALARM;
          alarmNext = 1'b1;
          ackNext   = 1'b0;
          evtNext   = (evtQ == {EVT_W{1'b1}}) ? evtQ : evtQ + EVT_W'(1);
        end else if (validAbn) begin
          stateNext = ST_SUSPECT;
        end else if (validNorm) begin
          stateNext = ST_NORMAL;
        end
      end
      ST_ALARM: begin
        if (alarm_ack) begin
          ackNext = 1'b1;
        end
        if (clrHit) begin
          stateNext = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (alarm_ack) begin
          ackNext = 1'b1;
        end
        // A relapse takes priority over releasing the alarm.
        if (validAbn) begin
          stateNext = ST_ALARM;
        end else if (ackQ || alarm_ack) begin
          stateNext = ST_NORMAL;
          alarmNext = 1'b0;
          ackNext   = 1'b0;
        end
      end
      default: begin
        stateNext = ST_NORMAL;
      end
    endcase

    buzzerNext = alarmNext && !ackNext;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_NORMAL;
      alarmQ  <= 1'b0;
      ackQ    <= 1'b0;
      buzzerQ <= 1'b0;
      evtQ    <= '0;
    end else begin
      state   <= stateNext;
      alarmQ  <= alarmNext;
      ackQ    <= ackNext;
      buzzerQ <= buzzerNext;
      evtQ    <= evtNext;
    end
  end

`ifdef PRESSURE_PEAK_TRACK_EN
  logic [PRESSURE_W-1:0] peakQ;

  // Peak of the episode; the first abnormal sample out of NORMAL restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peakQ <= '0;
    end else if (validAbn) begin
      if (state == ST_NORMAL) begin
        peakQ <= pressure_data;
      end else if (pressure_data > peakQ) begin
        peakQ <= pressure_data;
      end
    end
  end

  assign peak_pressure = peakQ;
`else
  logic unusedPressure;

  assign unusedPressure = ^pressure_data;
  assign peak_pressure  = '0;
`endif

  assign alarm       = alarmQ;
  assign buzzer      = buzzerQ;
  assign alarm_state = state;
  assign event_count = evtQ;

endmodule

// File: tb/tb_pressure_alarm_controller.sv
// tb_pressure_alarm_controller
// Directed scenarios followed by randomized samples; every cycle both DUTs
// (EVT_W=8 and EVT_W=2) are compared against an episode-level reference model.
module tb_pressure_alarm_controller;

  localparam int CONFIRM = 4;
  localparam int CLEAR   = 8;

  logic       clk;
  logic       rst_n;
  logic       sample_valid;
  logic       pressure_abnormal;
  logic [5:0] pressure_data;
  logic       alarm_ack;

  logic       alarmA, buzzerA, alarmB, buzzerB;
  logic [1:0] stateA, stateB;
  logic [7:0] evtA;
  logic [1:0] evtB;
  logic [5:0] peakA, peakB;

  int checks = 0;
  int errors = 0;

  // Reference model: alarm latch plus run lengths, no state machine encoding.
  bit mAlarm, mRecover, mAck;
  int mRun, mClr, mEvents, mPeak;

  pressure_alarm_controller uDutA (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_valid     (sample_valid),
    .pressure_abnormal(pressure_abnormal),
    .pressure_data    (pressure_data),
    .alarm_ack        (alarm_ack),
    .alarm            (alarmA),
    .buzzer           (buzzerA),
    .alarm_state      (stateA),
    .event_count      (evtA),
    .peak_pressure    (peakA)
  );

  pressure_alarm_controller #(.EVT_W(2)) uDutB (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_valid     (sample_valid),
    .pressure_abnormal(pressure_abnormal),
    .pressure_data    (pressure_data),
    .alarm_ack        (alarm_ack),
    .alarm            (alarmB),
    .buzzer           (buzzerB),
    .alarm_state      (stateB),
    .event_count      (evtB),
    .peak_pressure    (peakB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mReset();
    mAlarm = 0; mRecover = 0; mAck = 0;
    mRun = 0; mClr = 0; mEvents = 0; mPeak = 0;
  endtask

  function automatic int expPeak();
`ifdef PRESSURE_PEAK_TRACK_EN
    return mPeak;
`else
    return 0;
`endif
  endfunction

  function automatic int expState();
    if (!mAlarm) return (mRun > 0) ? 1 : 0;
    return mRecover ? 3 : 2;
  endfunction

  task automatic modelStep(input bit v, input bit a, input int d, input bit k);
    if (!mAlarm) begin
      if (v && a) begin
        mPeak = (mRun == 0) ? d : ((d > mPeak) ? d : mPeak);
        mRun  = (mRun < 15) ? mRun + 1 : 15;
        if (mRun >= CONFIRM) begin
          mAlarm = 1; mRecover = 0; mAck = 0; mRun = 0; mClr = 0;
          mEvents++;
        end
      end else if (v) begin
        mRun = 0;
      end
    end else if (!mRecover) begin
      if (k) mAck = 1;
      if (v && a) begin
        if (d > mPeak) mPeak = d;
        mClr = 0;
      end else if (v) begin
        mClr = (mClr < 15) ? mClr + 1 : 15;
        if (mClr >= CLEAR) mRecover = 1;
      end
    end else begin
      if (k) mAck = 1;
      if (v && a) begin
        if (d > mPeak) mPeak = d;
        mRecover = 0; mClr = 0;
      end else if (mAck) begin
        mAlarm = 0; mRecover = 0; mAck = 0;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    int evtSatA, evtSatB;
    evtSatA = (mEvents > 255) ? 255 : mEvents;
    evtSatB = (mEvents > 3) ? 3 : mEvents;
    chk({tag, ".alarm"},  32'(alarmA),  32'(mAlarm));
    chk({tag, ".buzzer"}, 32'(buzzerA), 32'(mAlarm && !mAck));
    chk({tag, ".state"},  32'(stateA),  32'(expState()));
    chk({tag, ".evt"},    32'(evtA),    32'(evtSatA));
    chk({tag, ".peak"},   32'(peakA),   32'(expPeak()));
    chk({tag, ".alarmB"}, 32'(alarmB),  32'(mAlarm));
    chk({tag, ".buzzB"},  32'(buzzerB), 32'(mAlarm && !mAck));
    chk({tag, ".stateB"}, 32'(stateB),  32'(expState()));
    chk({tag, ".evtB"},   32'(evtB),    32'(evtSatB));
    chk({tag, ".peakB"},  32'(peakB),   32'(expPeak()));
  endtask

  task automatic step(input string tag, input bit v, input bit a, input int d, input bit k);
    sample_valid      = v;
    pressure_abnormal = a;
    pressure_data     = 6'(d);
    alarm_ack         = k;
    @(posedge clk);
    modelStep(v, a, d, k);
    #1;
    checkModel(tag);
  endtask

  task automatic episode(input string tag);
    for (int i = 0; i < CONFIRM; i++) step(tag, 1, 1, int'($urandom_range(0, 63)), 0);
    step(tag, 0, 0, 0, 1);
    for (int i = 0; i < CLEAR; i++) step(tag, 1, 0, int'($urandom_range(0, 63)), 0);
    step(tag, 0, 0, 0, 0);
  endtask

  initial begin
    int pAbn;
    rst_n = 1'b0;
    sample_valid = 1'b0; pressure_abnormal = 1'b0; pressure_data = '0; alarm_ack = 1'b0;
    mReset();
    repeat (3) @(posedge clk);
    #1;
    checkModel("reset");
    chk("reset.state_const", 32'(stateA), 32'd0);
    #2 rst_n = 1'b1;

    // Confirm after four abnormal samples.
    step("confirm1", 1, 1, 40, 0);
    chk("confirm1.state_const", 32'(stateA), 32'd1);
    step("confirm2", 1, 1, 44, 0);
    step("confirm3", 1, 1, 50, 0);
    step("confirm4", 1, 1, 42, 0);
    chk("confirm.alarm_const", 32'(alarmA), 32'd1);
    chk("confirm.buzzer_const", 32'(buzzerA), 32'd1);
    chk("confirm.evt_const", 32'(evtA), 32'd1);
`ifdef PRESSURE_PEAK_TRACK_EN
    chk("confirm.peak_const", 32'(peakA), 32'd50);
`else
    chk("confirm.peak_const", 32'(peakA), 32'd0);
`endif

    // Acknowledge, then clear out through RECOVER.
    step("ack", 0, 0, 0, 1);
    chk("ack.buzzer_const", 32'(buzzerA), 32'd0);
    chk("ack.alarm_const", 32'(alarmA), 32'd1);
    for (int i = 0; i < CLEAR; i++) step("clear", 1, 0, 10, 0);
    chk("clear.recover_const", 32'(stateA), 32'd3);
    step("release", 0, 0, 0, 0);
    chk("release.state_const", 32'(stateA), 32'd0);
    chk("release.alarm_const", 32'(alarmA), 32'd0);

    // Interrupted run never alarms.
    step("interrupt1", 1, 1, 20, 0);
    step("interrupt2", 1, 1, 21, 0);
    step("interrupt3", 1, 1, 22, 0);
    step("interrupt4", 1, 0, 5, 0);
    chk("interrupt.normal_const", 32'(stateA), 32'd0);
    step("interrupt5", 1, 1, 23, 0);
    chk("interrupt.suspect_const", 32'(stateA), 32'd1);
    step("interrupt6", 1, 0, 5, 0);

    // Relapse from RECOVER without ack.
    for (int i = 0; i < CONFIRM; i++) step("relapse.raise", 1, 1, 30 + i, 0);
    for (int i = 0; i < CLEAR; i++) step("relapse.clear", 1, 0, 3, 0);
    chk("relapse.recover_const", 32'(stateA), 32'd3);
    step("relapse.idle", 1, 0, 3, 0);
    step("relapse.abn", 1, 1, 60, 0);
    chk("relapse.alarm_state_const", 32'(stateA), 32'd2);
    chk("relapse.evt_const", 32'(evtA), 32'd2);
    chk("relapse.buzzer_const", 32'(buzzerA), 32'd1);

    // Asynchronous reset between edges mid-ALARM.
    #3 rst_n = 1'b0;
    #1;
    mReset();
    chk("async.alarm", 32'(alarmA), 32'd0);
    chk("async.buzzer", 32'(buzzerA), 32'd0);
    chk("async.evt", 32'(evtA), 32'd0);
    chk("async.peak", 32'(peakA), 32'd0);
    @(posedge clk);
    #1;
    checkModel("async.hold");
    #2 rst_n = 1'b1;

    // Event counter saturation on the narrow instance.
    for (int e = 0; e < 5; e++) episode("sat");
    chk("sat.evtB_const", 32'(evtB), 32'd3);
    chk("sat.evtA_const", 32'(evtA), 32'd5);

    // Randomized phase with alternating abnormal pressure.
    for (int c = 0; c < 1200; c++) begin
      pAbn = ((c / 40) % 2 == 0) ? 80 : 15;
      step("rand",
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) < pAbn,
           int'($urandom_range(0, 63)),
           $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
